// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, persistence filter,
// registered rise/fall/event pulses, and sticky status with irq aggregation.
module multi_edge_detect #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     din_i,
    input  logic [2*WIDTH-1:0]   mode_i,
    input  logic [WIDTH-1:0]     clr_i,
    output logic [WIDTH-1:0]     level_o,
    output logic [WIDTH-1:0]     rise_o,
    output logic [WIDTH-1:0]     fall_o,
    output logic [WIDTH-1:0]     event_o,
    output logic [WIDTH-1:0]     status_o,
    output logic                 irq_o
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  level_q, level_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [WIDTH-1:0]                  event_q, event_d;
    logic [WIDTH-1:0]                  status_q, status_d;
    logic [WIDTH-1:0]                  s;
    mode_e                             ch_mode;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din_i};
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = '0;
        fall_d   = '0;
        event_d  = '0;
        ch_mode  = MODE_OFF;
        // A set from the previous event cycle overrides a clear on the same edge.
        status_d = (status_q & ~clr_i) | event_q;

        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end

            ch_mode = mode_e'(mode_i[2*i +: 2]);
            case (ch_mode)
                MODE_RISE: event_d[i] = rise_d[i];
                MODE_FALL: event_d[i] = fall_d[i];
                MODE_BOTH: event_d[i] = rise_d[i] | fall_d[i];
                default:   event_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            event_q  <= '0;
            status_q <= '0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            event_q  <= event_d;
            status_q <= status_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign event_o  = event_q;
    assign status_o = status_q;
    assign irq_o    = |status_q;

endmodule
